dram_req_scheduler: RTL

- Front-end scheduler for dram_ctrl_fsm.
- Arbitrates round-robin between NUM_REQ requesters and an internal periodic refresh timer.
- Issues exactly one operation at a time to the controller FSM and waits for it to return idle before issuing the next.
- Sits between the host-side request ports and dram_ctrl_fsm (drives its addr_val, refresh_flag, bank_id, row_id, col_id and offset inputs).

---
 rtl/dram_ctrl_pkg.sv | 20 ++
 rtl/dram_rr_arbiter.sv | 52 +++++
 rtl/dram_req_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and default geometry for the DRAM request scheduler and its arbiter.
package dram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        REF_ISSUE,
        REF_WAIT
    } state_t;

    localparam int DEF_BANKS            = 8;
    localparam int DEF_ROWS             = 128;
    localparam int DEF_COLS             = 8;
    localparam int DEF_NUM_REQ          = 4;
    localparam int DEF_REFRESH_INTERVAL = 780;
    localparam int DEF_MAX_POSTPONE     = 8;
    localparam int OFFSET_W             = 10;

endpackage

// File: rtl/dram_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters; the pointer moves past the winner on each accepted grant.
module dram_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_grant_idx,
    output logic               o_any
);

    localparam int SW = IW + 1;

    logic [IW-1:0] r_ptr;
    logic [SW-1:0] w_sum;
    logic [IW-1:0] w_idx;

    // Scan from the pointer upward, wrapping modulo NUM_REQ; the first hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            w_idx = w_sum[IW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any       = 1'b1;
                o_grant_idx = w_idx;
            end
        end
        if (o_any) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == IW'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dram_req_scheduler.sv
// Front-end scheduler for dram_ctrl_fsm: arbitrates host requests against a periodic refresh
// timer and hands exactly one operation at a time to the controller.
module dram_req_scheduler
    import dram_ctrl_pkg::*;
#(
    parameter  int NUMBER_OF_BANKS  = DEF_BANKS,
    parameter  int NUMBER_OF_ROWS   = DEF_ROWS,
    parameter  int NUMBER_OF_COLS   = DEF_COLS,
    parameter  int NUM_REQ          = DEF_NUM_REQ,
    parameter  int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter  int MAX_POSTPONE     = DEF_MAX_POSTPONE,
    localparam int BW = $clog2(NUMBER_OF_BANKS),
    localparam int RW = $clog2(NUMBER_OF_ROWS),
    localparam int CW = $clog2(NUMBER_OF_COLS),
    localparam int IW = $clog2(NUM_REQ),
    localparam int PW = $clog2(MAX_POSTPONE + 1),
    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*BW-1:0]       req_bank,
    input  logic [NUM_REQ*RW-1:0]       req_row,
    input  logic [NUM_REQ*CW-1:0]       req_col,
    input  logic [NUM_REQ*OFFSET_W-1:0] req_offset,
    input  logic                        ctrl_idle,
    output logic                        addr_val,
    output logic                        refresh_flag,
    output logic [BW-1:0]               bank_id,
    output logic [RW-1:0]               row_id,
    output logic [CW-1:0]               col_id,
    output logic [OFFSET_W-1:0]         offset,
    output logic [IW-1:0]               grant_id,
    output logic [PW-1:0]               refresh_pending,
    output logic                        refresh_overflow
);

    state_t              r_state;
    state_t              w_next;
    logic [TW-1:0]       r_ref_cnt;
    logic [PW-1:0]       r_pending;
    logic                r_overflow;
    logic                r_addr_val;
    logic                r_refresh_flag;
    logic [BW-1:0]       r_bank;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic [OFFSET_W-1:0] r_offset;
    logic [IW-1:0]       r_grant_id;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IW-1:0]       w_win;
    logic                w_any;
    logic                w_tick;
    logic                w_ref_done;
    logic                w_pend_max;
    logic                w_transfer;

    logic [BW-1:0]       w_bank_arr [NUM_REQ];
    logic [RW-1:0]       w_row_arr  [NUM_REQ];
    logic [CW-1:0]       w_col_arr  [NUM_REQ];
    logic [OFFSET_W-1:0] w_off_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_bank_arr[g] = req_bank[g*BW +: BW];
        assign w_row_arr[g]  = req_row[g*RW +: RW];
        assign w_col_arr[g]  = req_col[g*CW +: CW];
        assign w_off_arr[g]  = req_offset[g*OFFSET_W +: OFFSET_W];
    end

    dram_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req_valid),
        .i_advance   (w_transfer),
        .o_grant     (w_grant),
        .o_grant_idx (w_win),
        .o_any       (w_any)
    );

    assign w_tick     = (r_ref_cnt == TW'(REFRESH_INTERVAL - 1));
    assign w_ref_done = (r_state == REF_WAIT) && ctrl_idle;
    assign w_pend_max = (r_pending == PW'(MAX_POSTPONE));
    // A saturated refresh backlog takes precedence over any requester.
    assign w_transfer = (r_state == IDLE) && ctrl_idle && !w_pend_max && w_any;
    assign req_ready  = (w_transfer && !rst) ? w_grant : '0;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (ctrl_idle) begin
                    if (w_pend_max) begin
                        w_next = REF_ISSUE;
                    end else if (w_any) begin
                        w_next = ISSUE;
                    end else if (r_pending != '0) begin
                        w_next = REF_ISSUE;
                    end
                end
            end
            ISSUE:     if (!ctrl_idle) w_next = WAIT;
            WAIT:      if (ctrl_idle)  w_next = IDLE;
            REF_ISSUE: if (!ctrl_idle) w_next = REF_WAIT;
            REF_WAIT:  if (ctrl_idle)  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr_val     <= 1'b0;
            r_refresh_flag <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_addr_val     <= (w_next == ISSUE);
            r_refresh_flag <= (w_next == REF_ISSUE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_offset   <= '0;
            r_grant_id <= '0;
        end else if (w_transfer) begin
            r_bank     <= w_bank_arr[w_win];
            r_row      <= w_row_arr[w_win];
            r_col      <= w_col_arr[w_win];
            r_offset   <= w_off_arr[w_win];
            r_grant_id <= w_win;
        end
    end

    // A tick and a completed refresh in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt  <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ref_cnt <= w_tick ? '0 : r_ref_cnt + 1'b1;
            if (w_tick && !w_ref_done) begin
                if (w_pend_max) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + 1'b1;
                end
            end else if (w_ref_done && !w_tick) begin
                r_pending <= r_pending - 1'b1;
            end
        end
    end

    assign addr_val         = r_addr_val;
    assign refresh_flag     = r_refresh_flag;
    assign bank_id          = r_bank;
    assign row_id           = r_row;
    assign col_id           = r_col;
    assign offset           = r_offset;
    assign grant_id         = r_grant_id;
    assign refresh_pending  = r_pending;
    assign refresh_overflow = r_overflow;

endmodule
